// File: rtl/hash_exact_matcher_pkg.sv
// hash_exact_matcher_pkg: shared FSM encodings and descriptor layout for the exact-match lookup.
package hash_exact_matcher_pkg;
  localparam logic [2:0] MTX_STATE_IDLE       = 3'd0;
  localparam logic [2:0] MTX_STATE_LOAD_KEY   = 3'd1;
  localparam logic [2:0] MTX_STATE_HASH       = 3'd2;
  localparam logic [2:0] MTX_STATE_LOAD_ENTRY = 3'd3;
  localparam logic [2:0] MTX_STATE_COMPARE    = 3'd4;
  localparam logic [2:0] MTX_STATE_DONE       = 3'd5;
  localparam int MTX_META_W = 27;
  // Sits directly above base_addr in cfg_data_i, valid at the top.
  typedef struct packed {
    logic       valid;
    logic [7:0] key_off;
    logic [4:0] key_len;
    logic [7:0] entry_len;
    logic [4:0] log2_depth;
  } mtx_meta_t;
endpackage

// File: rtl/hash_exact_matcher_byte_burst_reader.sv
// byte_burst_reader: issues count sequential 1-byte reads from base; first address goes out in the go cycle.
module byte_burst_reader #(
  parameter int ADDR_W = 32,
  parameter int CW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [CW-1:0]     count,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              byte_valid,
  output logic [CW-1:0]     byte_idx,
  output logic              done
);
  logic act, last;
  logic [ADDR_W-1:0] base_r;
  logic [CW-1:0] cnt_r, idx, cur_idx, cur_cnt;
  always_comb begin
    cur_idx = go ? '0 : idx;
    cur_cnt = go ? count : cnt_r;
    mem_ce = go | act;
    mem_addr = (go ? base : base_r) + ADDR_W'(cur_idx);
    done = byte_valid & last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act <= 1'b0;
      last <= 1'b0;
      base_r <= '0;
      cnt_r <= '0;
      idx <= '0;
      byte_valid <= 1'b0;
      byte_idx <= '0;
    end else begin
      if (go) begin
        base_r <= base;
        cnt_r <= count;
      end
      idx <= cur_idx + 1'b1;
      act <= mem_ce && (cur_idx + 1'b1 != cur_cnt);
      last <= mem_ce && (cur_idx + 1'b1 == cur_cnt);
      byte_valid <= mem_ce;
      byte_idx <= cur_idx;
    end
endmodule

// File: rtl/hash_exact_matcher.sv
// hash_exact_matcher: exact-match lookup of a packet key in one of several hash tables with linear probing.
module hash_exact_matcher
  import hash_exact_matcher_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int KEY_BYTES = 16,
  parameter int NUM_TABLES = 4,
  parameter int NUM_WAYS = 2,
  parameter int PKT_BASE = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [$clog2(NUM_TABLES)-1:0] tab_id_i,
  output logic                          busy_o,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NUM_TABLES)-1:0] cfg_tab_i,
  input  logic [2*ADDR_W-1:0]           cfg_data_i,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [3:0]                    mem_width_o,
  input  logic [31:0]                   mem_data_i,
  output logic                          hash_start_o,
  output logic [8*KEY_BYTES-1:0]        hash_key_o,
  input  logic                          hash_ready_i,
  input  logic [31:0]                   hash_val_i,
  output logic                          match_valid_o,
  output logic                          hit_o,
  output logic                          err_o,
  output logic [$clog2(NUM_WAYS):0]     way_o,
  output logic [ADDR_W-1:0]             val_addr_o
);
  localparam int WW = $clog2(NUM_WAYS) + 1;
  localparam int CW = $clog2(KEY_BYTES + 2);
  localparam int KW = $clog2(KEY_BYTES);
  mtx_meta_t cfg_m [NUM_TABLES];
  logic [ADDR_W-1:0] cfg_b [NUM_TABLES];
  mtx_meta_t d, sel;
  logic [ADDR_W-1:0] d_base, ent_addr, rd_base;
  logic [2:0] state;
  logic kick, occ, mis, bad, ldk, rd_valid, rd_done, unused;
  logic [31:0] bkt, mask;
  logic [WW-1:0] w;
  logic [CW-1:0] rd_cnt, rd_idx;
  logic [0:KEY_BYTES-1][7:0] key;
  always_comb begin
    sel = cfg_m[tab_id_i];
    bad = !sel.valid || sel.key_len == '0 || int'(sel.key_len) > KEY_BYTES;
    mask = (32'd1 << d.log2_depth) - 32'd1;
    ent_addr = d_base + ADDR_W'((bkt + 32'(w)) & mask) * ADDR_W'(d.entry_len);
    ldk = state == MTX_STATE_LOAD_KEY;
    rd_base = ldk ? ADDR_W'(PKT_BASE) + ADDR_W'(d.key_off) : ent_addr;
    rd_cnt = ldk ? CW'(d.key_len) : CW'(d.key_len) + 1'b1;
    hash_start_o = state == MTX_STATE_HASH;
    hash_key_o = key;
    mem_we_o = 1'b0;
    mem_width_o = 4'd1;
    unused = ^{cfg_data_i[2*ADDR_W-1:ADDR_W+MTX_META_W], mem_data_i[31:8], d.valid};
  end
  byte_burst_reader #(.ADDR_W(ADDR_W), .CW(CW)) u_rd (
    .clk(clk), .rst_n(rst_n), .go(kick), .base(rd_base), .count(rd_cnt),
    .mem_ce(mem_ce_o), .mem_addr(mem_addr_o), .byte_valid(rd_valid),
    .byte_idx(rd_idx), .done(rd_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_TABLES; i++) begin
        cfg_m[i] <= '0;
        cfg_b[i] <= '0;
      end
    else if (cfg_we_i) begin
      cfg_m[cfg_tab_i] <= mtx_meta_t'(cfg_data_i[ADDR_W +: MTX_META_W]);
      cfg_b[cfg_tab_i] <= cfg_data_i[ADDR_W-1:0];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MTX_STATE_IDLE;
      kick <= 1'b0;
      occ <= 1'b0;
      mis <= 1'b0;
      bkt <= '0;
      w <= '0;
      key <= '0;
      d <= '0;
      d_base <= '0;
      busy_o <= 1'b0;
      match_valid_o <= 1'b0;
      hit_o <= 1'b0;
      err_o <= 1'b0;
      way_o <= '0;
      val_addr_o <= '0;
    end else begin
      kick <= 1'b0;
      case (state)
        MTX_STATE_IDLE: if (start_i) begin
          d <= sel;
          d_base <= cfg_b[tab_id_i];
          busy_o <= 1'b1;
          hit_o <= 1'b0;
          err_o <= bad;
          way_o <= WW'(NUM_WAYS);
          val_addr_o <= '0;
          key <= '0;
          match_valid_o <= bad;
          kick <= !bad;
          state <= bad ? MTX_STATE_DONE : MTX_STATE_LOAD_KEY;
        end
        MTX_STATE_LOAD_KEY: begin
          if (rd_valid) key[KW'(rd_idx)] <= mem_data_i[7:0];
          if (rd_done) state <= MTX_STATE_HASH;
        end
        MTX_STATE_HASH: if (hash_ready_i) begin
          bkt <= hash_val_i & mask;
          w <= '0;
          mis <= 1'b0;
          kick <= 1'b1;
          state <= MTX_STATE_LOAD_ENTRY;
        end
        MTX_STATE_LOAD_ENTRY: begin
          // Byte 0 is the occupied flag; key bytes are compared as they stream in.
          if (rd_valid) begin
            if (rd_idx == '0) occ <= mem_data_i[0];
            else if (mem_data_i[7:0] != key[KW'(rd_idx - 1'b1)]) mis <= 1'b1;
          end
          if (rd_done) state <= MTX_STATE_COMPARE;
        end
        MTX_STATE_COMPARE:
          if (occ && !mis) begin
            hit_o <= 1'b1;
            way_o <= w;
            val_addr_o <= ent_addr + ADDR_W'(d.key_len) + 1'b1;
            match_valid_o <= 1'b1;
            state <= MTX_STATE_DONE;
          end else if (!occ || w == WW'(NUM_WAYS - 1)) begin
            match_valid_o <= 1'b1;
            state <= MTX_STATE_DONE;
          end else begin
            w <= w + 1'b1;
            mis <= 1'b0;
            kick <= 1'b1;
            state <= MTX_STATE_LOAD_ENTRY;
          end
        MTX_STATE_DONE: begin
          match_valid_o <= 1'b0;
          busy_o <= 1'b0;
          state <= MTX_STATE_IDLE;
        end
        default: state <= MTX_STATE_IDLE;
      endcase
    end
endmodule
